// File: rtl/cuckoo_pkg.sv
// Shared types and hash constants for the cuckoo insert path
// (index generator and insert stage).
package cuckoo_pkg;

   localparam logic [31:0] HASH_C1 = 32'h9E3779B1;
   localparam logic [31:0] HASH_C2 = 32'h85EBCA6B;

   localparam int DEF_KEY_W = 32;
   localparam int DEF_IDX_W = 5;
   localparam int DEF_SEQ_W = 8;

   typedef logic [DEF_IDX_W-1:0] idx_t;

   typedef struct packed {
      logic                 valid;
      logic [DEF_KEY_W-1:0] key;
      logic [DEF_SEQ_W-1:0] seq;
      logic [31:0]          p1;
      logic [31:0]          p2;
   } pipe_stage_t;

endpackage

// File: rtl/cuckoo_hash_fold.sv
// Multiplicative hash split across a pipeline register: key -> truncated
// 32-bit product on one side, registered product -> top IDX_W bits on the other.
module cuckoo_hash_fold #(
   parameter logic [31:0] C     = 32'h1,
   parameter int          IDX_W = 5
) (
   input  logic [31:0]      key,
   output logic [31:0]      prod,
   input  logic [31:0]      prod_in,
   output logic [IDX_W-1:0] idx
);

   assign prod = key * C;
   assign idx  = IDX_W'(prod_in >> (32 - IDX_W));

endmodule

// File: rtl/cuckoo_index_gen.sv
// Three-stage stallable feeder computing two distinct cuckoo table indices per key.
// Optional macro CUCKOO_COLLISION_CNT_EN adds a saturating collision_cnt output.
module cuckoo_index_gen
   import cuckoo_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W,
   parameter int IDX_W = DEF_IDX_W,
   parameter int SEQ_W = DEF_SEQ_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] out_key,
   output logic [IDX_W-1:0] out_index1,
   output logic [IDX_W-1:0] out_index2,
   output logic [SEQ_W-1:0] out_seq
`ifdef CUCKOO_COLLISION_CNT_EN
   ,
   output logic [15:0]      collision_cnt
`endif
);

   logic             adv;
   logic             accept;
   logic             collide;
   logic [31:0]      prod1, prod2;
   logic [IDX_W-1:0] h1, h2;

   logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
   logic             s1_valid_q, s1_valid_d;
   logic [KEY_W-1:0] s1_key_q, s1_key_d;
   logic [SEQ_W-1:0] s1_seq_q, s1_seq_d;
   pipe_stage_t      s2_q, s2_d;
   logic             s3_valid_q, s3_valid_d;
   logic [KEY_W-1:0] s3_key_q, s3_key_d;
   logic [IDX_W-1:0] s3_idx1_q, s3_idx1_d;
   logic [IDX_W-1:0] s3_idx2_q, s3_idx2_d;
   logic [SEQ_W-1:0] s3_seq_q, s3_seq_d;

   cuckoo_hash_fold #(.C(HASH_C1), .IDX_W(IDX_W)) u_fold1 (
      .key     (s1_key_q),
      .prod    (prod1),
      .prod_in (s2_q.p1),
      .idx     (h1)
   );

   cuckoo_hash_fold #(.C(HASH_C2), .IDX_W(IDX_W)) u_fold2 (
      .key     (s1_key_q),
      .prod    (prod2),
      .prod_in (s2_q.p2),
      .idx     (h2)
   );

   assign collide = (h2 == h1);

   always_comb begin
      adv      = !s3_valid_q || out_ready;
      accept   = in_valid && adv;
      in_ready = adv;

      // NOTE: every signal gets its hold value first, so no path leaves it
      // unassigned and no latch is inferred.
      seq_cnt_d  = seq_cnt_q + SEQ_W'(accept);
      s1_valid_d = s1_valid_q;
      s1_key_d   = s1_key_q;
      s1_seq_d   = s1_seq_q;
      s2_d       = s2_q;
      s3_valid_d = s3_valid_q;
      s3_key_d   = s3_key_q;
      s3_idx1_d  = s3_idx1_q;
      s3_idx2_d  = s3_idx2_q;
      s3_seq_d   = s3_seq_q;

      // Bubbles shift like real entries so latency stays fixed at three.
      if (adv) begin
         s1_valid_d = in_valid;
         s1_key_d   = accept ? in_key : s1_key_q;
         s1_seq_d   = seq_cnt_q;

         s2_d.valid = s1_valid_q;
         s2_d.key   = s1_key_q;
         s2_d.seq   = s1_seq_q;
         s2_d.p1    = prod1;
         s2_d.p2    = prod2;

         s3_valid_d = s2_q.valid;
         s3_key_d   = s2_q.key;
         s3_seq_d   = s2_q.seq;
         s3_idx1_d  = h1;
         s3_idx2_d  = collide ? (h1 ^ IDX_W'(1)) : h2;
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_key_q   <= '0;
         s1_seq_q   <= '0;
         s2_q       <= '0;
         s3_valid_q <= 1'b0;
         s3_key_q   <= '0;
         s3_idx1_q  <= '0;
         s3_idx2_q  <= '0;
         s3_seq_q   <= '0;
      end else begin
         seq_cnt_q  <= seq_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_key_q   <= s1_key_d;
         s1_seq_q   <= s1_seq_d;
         s2_q       <= s2_d;
         s3_valid_q <= s3_valid_d;
         s3_key_q   <= s3_key_d;
         s3_idx1_q  <= s3_idx1_d;
         s3_idx2_q  <= s3_idx2_d;
         s3_seq_q   <= s3_seq_d;
      end
   end

   assign out_valid  = s3_valid_q;
   assign out_key    = s3_key_q;
   assign out_index1 = s3_idx1_q;
   assign out_index2 = s3_idx2_q;
   assign out_seq    = s3_seq_q;

`ifdef CUCKOO_COLLISION_CNT_EN
   logic [15:0] coll_cnt_q, coll_cnt_d;

   // Counted as the forced-XOR entry loads into the output stage.
   always_comb begin
      coll_cnt_d = coll_cnt_q;
      if (adv && s2_q.valid && collide && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_d = coll_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coll_cnt_q <= '0;
      end else begin
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign collision_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_cuckoo_index_gen.sv
// Scoreboard bench for cuckoo_index_gen: driver pushes model predictions on
// accept, an independent monitor pops and compares on each consumed output.
module tb_cuckoo_index_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_key;
   logic [4:0]  out_index1;
   logic [4:0]  out_index2;
   logic [7:0]  out_seq;

   always #5 clk = ~clk;

   cuckoo_index_gen dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_key     (in_key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_key    (out_key),
      .out_index1 (out_index1),
      .out_index2 (out_index2),
      .out_seq    (out_seq)
   );

   typedef struct {
      logic [31:0] key;
      logic [4:0]  i1;
      logic [4:0]  i2;
      logic [7:0]  seq;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   seq_model = 0;
   int   out_count = 0;
   int   last_seq  = -1;
   bit   mon_en    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference: full-width products reduced mod 2^32, index = product / 2^27.
   function automatic exp_t model(input logic [31:0] key, input int seq);
      exp_t            e;
      longint unsigned k, p1, p2;
      int unsigned     h1, h2;
      k  = key;
      p1 = (k * 64'h9E3779B1) % 64'h1_0000_0000;
      p2 = (k * 64'h85EBCA6B) % 64'h1_0000_0000;
      h1 = int'(p1 / 64'd134217728);
      h2 = int'(p2 / 64'd134217728);
      e.key = key;
      e.i1  = 5'(h1);
      e.i2  = (h1 == h2) ? 5'(h1 ^ 1) : 5'(h2);
      e.seq = 8'(seq);
      return e;
   endfunction

   task automatic drive(input bit v, input logic [31:0] k, input bit r, output bit acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_key    = k;
      out_ready = r;
      @(negedge clk);
      acc = (in_valid && in_ready);
      if (acc) begin
         exp_q.push_back(model(in_key, seq_model));
         seq_model = (seq_model + 1) % 256;
      end
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      seq_model = 0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         drive(1'b0, 32'h0, 1'b1, acc);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor
   bit          stall_hold = 1'b0;
   logic [31:0] held_key;
   logic [4:0]  held_i1, held_i2;
   logic [7:0]  held_seq;

   always @(negedge clk) begin
      if (rst || !mon_en) begin
         stall_hold = 1'b0;
      end else begin
         check("in_ready", in_ready, (!out_valid || out_ready));
         if (out_valid && !out_ready) begin
            if (stall_hold) begin
               check("stall_key", out_key, held_key);
               check("stall_idx1", out_index1, held_i1);
               check("stall_idx2", out_index2, held_i2);
               check("stall_seq", out_seq, held_seq);
            end
            held_key   = out_key;
            held_i1    = out_index1;
            held_i2    = out_index2;
            held_seq   = out_seq;
            stall_hold = 1'b1;
         end else begin
            stall_hold = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output: key 0x%0h seq %0d with nothing pending", out_key, out_seq);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_key", out_key, e.key);
               check("sb_idx1", out_index1, e.i1);
               check("sb_idx2", out_index2, e.i2);
               check("sb_seq", out_seq, e.seq);
            end
            out_count++;
            last_seq = int'(out_seq);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          i;
      int          base;
      int          accepted;
      int          budget;
      logic [31:0] bp_keys[4];

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_key    = '0;
      out_ready = 1'b0;

      // Reset state
      do_reset(2);
      mon_en = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_key", out_key, 0);
      check("rst_out_idx1", out_index1, 0);
      check("rst_out_idx2", out_index2, 0);
      check("rst_out_seq", out_seq, 0);
      check("rst_in_ready", in_ready, 1);

      // Single key: latency 3
      drive(1'b1, 32'd1, 1'b1, acc);
      check("single_accept", acc, 1);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("lat_n1_valid", out_valid, 0);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("lat_n2_valid", out_valid, 0);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("lat_n3_valid", out_valid, 1);
      check("single_idx1", out_index1, 19);
      check("single_idx2", out_index2, 16);
      check("single_key", out_key, 1);
      check("single_seq", out_seq, 0);

      // Back-to-back keys 1, 2, 0 (0 exercises the collision fix)
      do_reset(2);
      drive(1'b1, 32'd1, 1'b1, acc);
      drive(1'b1, 32'd2, 1'b1, acc);
      drive(1'b1, 32'd0, 1'b1, acc);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("b2b0_valid", out_valid, 1);
      check("b2b0_idx1", out_index1, 19);
      check("b2b0_idx2", out_index2, 16);
      check("b2b0_seq", out_seq, 0);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("b2b1_valid", out_valid, 1);
      check("b2b1_idx1", out_index1, 7);
      check("b2b1_idx2", out_index2, 1);
      check("b2b1_seq", out_seq, 1);
      drive(1'b0, 32'd0, 1'b1, acc);
      check("b2b2_valid", out_valid, 1);
      check("b2b2_idx1", out_index1, 0);
      check("b2b2_idx2", out_index2, 1);
      check("b2b2_seq", out_seq, 2);
      drain();

      // Backpressure: 4 keys streaming into 5 stalled cycles
      do_reset(1);
      base = out_count;
      for (int k = 0; k < 4; k++) bp_keys[k] = $urandom;
      i = 0;
      repeat (5) begin
         drive(i < 4, (i < 4) ? bp_keys[i] : 32'h0, 1'b0, acc);
         if (acc) i++;
      end
      check("bp_accepted_in_stall", i, 3);
      budget = 0;
      while (i < 4 && budget < 20) begin
         drive(1'b1, bp_keys[i], 1'b1, acc);
         if (acc) i++;
         budget++;
      end
      drain();
      check("bp_out_count", out_count - base, 4);
      check("bp_last_seq", last_seq, 3);

      // Randomised traffic through a seq wrap: 257 accepted keys
      do_reset(1);
      base     = out_count;
      accepted = 0;
      budget   = 0;
      while (accepted < 257 && budget < 3000) begin
         drive($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 7, acc);
         if (acc) accepted++;
         budget++;
      end
      drain();
      check("wrap_out_count", out_count - base, 257);
      check("wrap_last_seq", last_seq, 0);

      // Reset while stalled with keys in flight
      do_reset(1);
      for (int k = 0; k < 3; k++) drive(1'b1, $urandom, 1'b0, acc);
      drive(1'b0, 32'h0, 1'b0, acc);
      check("midstall_valid_before", out_valid, 1);
      base = out_count;
      do_reset(1);
      check("midstall_valid_after", out_valid, 0);
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, acc);
      drain();
      check("midstall_out_count", out_count - base, 1);
      check("midstall_seq", last_seq, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cuckoo_index_gen.md
Name: cuckoo_index_gen

Overview:
- Upstream feeder for the cuckoo insert stage.
- Accepts 32-bit keys over a valid/ready handshake and computes the two candidate table indices (index1 for table 1, index2 for table 2) with two multiplicative hashes.
- Presents {key, index1, index2, seq} downstream through a 3-stage stallable pipeline.
- Guarantees index1 != index2 so the insert stage never evicts into the same slot pair.

Parameters:
- KEY_W, 32: key width.
- IDX_W, 5: index width; table depth is 2**IDX_W (32).
- SEQ_W, 8: width of the per-key sequence tag.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream key valid.
- in_ready  out  1  block can accept a key this cycle.
- in_key  in  KEY_W  key to hash.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  insert stage consumes the bundle.
- out_key  out  KEY_W  key, passed through unchanged.
- out_index1  out  IDX_W  table-1 index.
- out_index2  out  IDX_W  table-2 index.
- out_seq  out  SEQ_W  acceptance order tag.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, sampled at a clk edge:
  - all stage valids clear, so out_valid=0;
  - out_key, out_index1, out_index2 and out_seq = 0;
  - the internal seq counter = 0.
- Advance: adv = !out_valid || out_ready. in_ready = adv, combinational and with no registered skid.
- Accept: a key is accepted when in_valid && in_ready. The handshake completes in that cycle.
- Pipeline, all registered and all moving only when adv=1:
  - S1: latch key and seq. seq_cnt increments by 1 mod 2**SEQ_W on each accept.
  - S2: p1 = (key * 32'h9E3779B1) mod 2^32 and p2 = (key * 32'h85EBCA6B) mod 2^32. Both are unsigned, truncated to 32 bits.
  - S3 (output): idx1 = p1[31:32-IDX_W] and h2 = p2[31:32-IDX_W]. If h2==idx1, then idx2 = idx1 ^ 1; otherwise idx2 = h2.
- Latency: a key accepted in cycle N gives out_valid=1 in cycle N+3 when there is no stall.
- Throughput: 1 key/cycle.
- Bubbles: an invalid stage still shifts when adv=1. Bubbles are not compressed while adv=1.
- Stall: when out_valid && !out_ready:
  - every stage holds, and in_ready=0;
  - the output bundle is stable, with no field changing until it is consumed.
- Simultaneous events: consume and accept in the same cycle both occur, and the pipeline shifts.
- seq wrap: 255 -> 0 with no flag.
- Reset mid-stall: in-flight keys are discarded and not replayed; seq restarts at 0.
- in_key is ignored when in_valid=0, and the counter does not move.

Optional Feature:
- Macro: CUCKOO_COLLISION_CNT_EN.
- When defined, port collision_cnt (out, 16) is added. It counts S3 outputs, valid and advancing, where h2==idx1 forced the XOR fix. It saturates at 16'hFFFF and resets to 0.
- When not defined, the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cuckoo_pkg holds:
  - constants HASH_C1=32'h9E3779B1 and HASH_C2=32'h85EBCA6B;
  - default IDX_W;
  - typedef idx_t (IDX_W bits);
  - typedef struct pipe_stage_t {valid, key, seq, p1, p2}, also reused by the insert stage.
- One sub-module, cuckoo_hash_fold (params C, IDX_W): 32-bit multiply, truncate, top-IDX_W extract. Instantiated twice.

Test Plan:
- Reset and single key: rst high 2 cycles, then in_key=1 accepted at cycle N -> at N+3, out_index1=19, out_index2=16, out_key=1, out_seq=0.
- Collision fix: in_key=0 -> out_index1=0, out_index2=1. With CUCKOO_COLLISION_CNT_EN defined, collision_cnt goes 0->1.
- Back-to-back: keys 1, 2, 0 on consecutive cycles with out_ready=1 -> outputs on 3 consecutive cycles:
  - (19,16,seq0)
  - (7,1,seq1)
  - (0,1,seq2)
- Backpressure: hold out_ready=0 for 5 cycles with 4 keys streaming -> in_ready=0 once out_valid=1, and the output bundle is stable. After release, all keys emerge in order with seq 0..3 and no loss or duplication.
- Seq wrap: 257 accepted keys -> the final key shows out_seq=0.
- Reset mid-stall: 3 keys in flight, out_ready=0, assert rst -> next cycle out_valid=0. The next accepted key gets out_seq=0.
